// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER data-memory port logic.
//   mst_e  : identifies which master owns an access (CPU load/store unit or loader/DMA)
//   SZ_*   : access size encodings carried on the MEM_SIZE field
package otter_mem_pkg;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_LDR = 1'b1
  } mst_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/otter_dmem_arbiter.sv
// Arbiter for the data port (port 2) of the OTTER dual-port byte memory.
//   M0 (CPU) has default priority; M1 (loader/DMA) is guaranteed progress by a
//   starvation counter and can take exclusive ownership with M1_LOCK.
// Ports:
//   MEM_CLK, RST                 clock and synchronous active-high reset
//   Mx_REQ/WE/ADDR/DIN/SIZE/SIGN request fields from master x (held until Mx_GNT)
//   Mx_GNT                       combinational accept for this cycle
//   Mx_RVALID, Mx_DOUT           load return, one cycle after the granted load
//   M1_LOCK                      loader ownership: M1 wins every cycle while high
//   MEM_*2, MEM_SIZE, MEM_SIGN   muxed access toward the memory
//   MEM_DOUT2                    memory read data, valid the cycle after MEM_READ2
module otter_dmem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        MEM_CLK,
  input  logic        RST,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_DIN,
  input  logic [1:0]  M0_SIZE,
  input  logic        M0_SIGN,
  output logic        M0_GNT,
  output logic        M0_RVALID,
  output logic [31:0] M0_DOUT,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_DIN,
  input  logic [1:0]  M1_SIZE,
  input  logic        M1_SIGN,
  output logic        M1_GNT,
  output logic        M1_RVALID,
  output logic [31:0] M1_DOUT,
  input  logic        M1_LOCK,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  mst_e             rd_owner_q, rd_owner_d;
  logic [31:0]      m0_dout_q, m0_dout_d;
  logic [31:0]      m1_dout_q, m1_dout_d;

  always_comb begin
    M0_GNT       = 1'b0;
    M1_GNT       = 1'b0;
    MEM_ADDR2    = M0_ADDR;
    MEM_DIN2     = M0_DIN;
    MEM_SIZE     = M0_SIZE;
    MEM_SIGN     = M0_SIGN;
    MEM_WRITE2   = 1'b0;
    MEM_READ2    = 1'b0;
    starve_cnt_d = starve_cnt_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;

    // Nothing is granted while in reset, so a request held through reset
    // never reaches the memory and never produces a read return.
    if (!RST) begin
      if (M1_LOCK) begin
        // Lock blocks M0 even when M1 has nothing to do this cycle.
        M1_GNT = M1_REQ;
      end else if ((starve_cnt_q == LIMIT_C) && M1_REQ) begin
        M1_GNT = 1'b1;
      end else if (M0_REQ) begin
        M0_GNT = 1'b1;
      end else if (M1_REQ) begin
        M1_GNT = 1'b1;
      end
    end

    if (M1_GNT) begin
      MEM_ADDR2  = M1_ADDR;
      MEM_DIN2   = M1_DIN;
      MEM_SIZE   = M1_SIZE;
      MEM_SIGN   = M1_SIGN;
      MEM_WRITE2 = M1_WE;
      MEM_READ2  = !M1_WE;
      rd_owner_d = MST_LDR;
    end else if (M0_GNT) begin
      MEM_WRITE2 = M0_WE;
      MEM_READ2  = !M0_WE;
      rd_owner_d = MST_CPU;
    end

    rd_pend_d = MEM_READ2;

    // Counts consecutive denied M1 cycles; once it reaches the limit the
    // next M1 request is forced through, which clears it again.
    if (M1_GNT || !M1_REQ) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT_C) begin
      starve_cnt_d = starve_cnt_q + ONE_C;
    end

    // Read data is forwarded combinationally in the return cycle and latched
    // so each master's DOUT holds its last load result afterwards.
    M0_RVALID = !RST && rd_pend_q && (rd_owner_q == MST_CPU);
    M1_RVALID = !RST && rd_pend_q && (rd_owner_q == MST_LDR);
    M0_DOUT   = M0_RVALID ? MEM_DOUT2 : m0_dout_q;
    M1_DOUT   = M1_RVALID ? MEM_DOUT2 : m1_dout_q;
    m0_dout_d = M0_DOUT;
    m1_dout_d = M1_DOUT;
  end

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= MST_CPU;
      m0_dout_q    <= '0;
      m1_dout_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      m0_dout_q    <= m0_dout_d;
      m1_dout_q    <= m1_dout_d;
    end
  end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
module tb_otter_dmem_arbiter;

  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_sign = 1'b0;
  logic [31:0] m0_addr = '0, m0_din = '0;
  logic [1:0]  m0_size = 2'd2;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_sign = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_addr = '0, m1_din = '0;
  logic [1:0]  m1_size = 2'd2;
  logic [31:0] mem_dout = '0;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_dout, m1_dout;
  logic [31:0] mem_addr2, mem_din2;
  logic        mem_write2, mem_read2, mem_sign;
  logic [1:0]  mem_size;

  int total = 0;
  int bad   = 0;

  otter_dmem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .MEM_CLK(clk), .RST(rst),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_DIN(m0_din),
    .M0_SIZE(m0_size), .M0_SIGN(m0_sign), .M0_GNT(m0_gnt), .M0_RVALID(m0_rvalid),
    .M0_DOUT(m0_dout),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_DIN(m1_din),
    .M1_SIZE(m1_size), .M1_SIGN(m1_sign), .M1_GNT(m1_gnt), .M1_RVALID(m1_rvalid),
    .M1_DOUT(m1_dout), .M1_LOCK(m1_lock),
    .MEM_ADDR2(mem_addr2), .MEM_DIN2(mem_din2), .MEM_WRITE2(mem_write2),
    .MEM_READ2(mem_read2), .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign),
    .MEM_DOUT2(mem_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port this cycle, how long M1 has waited,
  // and which master (if any) is owed read data next cycle.
  int          mdl_wait = 0;
  int          mdl_owed = -1;  // -1: no load outstanding, else master id
  logic [31:0] mdl_hold0 = '0, mdl_hold1 = '0;
  int          win;
  logic        sel_we;
  logic [31:0] sel_addr, sel_din;
  logic [1:0]  sel_size;
  logic        sel_sign;
  logic        exp_rv0, exp_rv1;

  always @(negedge clk) begin
    if (rst)                             win = -1;
    else if (m1_lock)                    win = m1_req ? 1 : -1;
    else if (m1_req && mdl_wait >= STARVE) win = 1;
    else if (m0_req)                     win = 0;
    else if (m1_req)                     win = 1;
    else                                 win = -1;

    sel_we   = (win == 1) ? m1_we   : m0_we;
    sel_addr = (win == 1) ? m1_addr : m0_addr;
    sel_din  = (win == 1) ? m1_din  : m0_din;
    sel_size = (win == 1) ? m1_size : m0_size;
    sel_sign = (win == 1) ? m1_sign : m0_sign;

    chk("m0_gnt", 32'(m0_gnt), 32'(win == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(win == 1));
    chk("mem_write2", 32'(mem_write2), 32'(win >= 0 && sel_we));
    chk("mem_read2", 32'(mem_read2), 32'(win >= 0 && !sel_we));
    chk("mem_addr2", mem_addr2, sel_addr);
    chk("mem_din2", mem_din2, sel_din);
    chk("mem_size", 32'(mem_size), 32'(sel_size));
    chk("mem_sign", 32'(mem_sign), 32'(sel_sign));

    exp_rv0 = !rst && (mdl_owed == 0);
    exp_rv1 = !rst && (mdl_owed == 1);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1));
    chk("m0_dout", m0_dout, exp_rv0 ? mem_dout : mdl_hold0);
    chk("m1_dout", m1_dout, exp_rv1 ? mem_dout : mdl_hold1);

    // Advance the model to the next cycle (inputs stay put until after posedge).
    if (rst) begin
      mdl_wait = 0; mdl_owed = -1; mdl_hold0 = '0; mdl_hold1 = '0;
    end else begin
      if (exp_rv0) mdl_hold0 = mem_dout;
      if (exp_rv1) mdl_hold1 = mem_dout;
      mdl_owed = (win >= 0 && !sel_we) ? win : -1;
      if (win == 1 || !m1_req) mdl_wait = 0;
      else if (mdl_wait < STARVE) mdl_wait++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int n0, n1, first_m1, nw;
  logic [31:0] vals[6];
  logic g0, g1;

  initial begin
    // 1: reset held two cycles with a pending M0 load
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    repeat (2) begin
      @(negedge clk);
      chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("rst_mem_read2", 32'(mem_read2), 32'd0);
      next_cycle();
    end
    rst = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    chk("post_rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("post_rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("post_rst_m0_dout", m0_dout, 32'd0);

    // 2: single M0 load with a known return value
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_size = 2'd2;
    @(negedge clk);
    chk("ld_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("ld_mem_addr", mem_addr2, 32'h100);
    next_cycle();
    m0_req = 1'b0; mem_dout = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("ld_m0_dout", m0_dout, 32'hDEADBEEF);
    chk("ld_m1_rvalid", 32'(m1_rvalid), 32'd0);

    // 3: both masters hammering; M1 forced in once every STARVE+1 cycles
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h200; m0_din = 32'h11;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h300; m1_din = 32'h22;
    n0 = 0; n1 = 0; first_m1 = -1;
    for (int i = 0; i < 2 * (STARVE + 1); i++) begin
      @(negedge clk);
      if (m0_gnt) n0++;
      if (m1_gnt) begin
        n1++;
        if (first_m1 < 0) first_m1 = i;
      end
      if (i != 2 * STARVE + 1) next_cycle();
    end
    chk("starve_m0_cnt", 32'(n0), 32'd16);
    chk("starve_m1_cnt", 32'(n1), 32'd2);
    chk("starve_first_m1", 32'(first_m1), 32'd8);

    // 4: locked loader stores block the CPU completely
    next_cycle();
    m1_lock = 1'b1; m1_addr = 32'h0; m1_we = 1'b1;
    m0_we = 1'b0; m0_addr = 32'h44;
    n0 = 0; nw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m0_gnt) n0++;
      if (m1_gnt && mem_write2 && mem_addr2 == 32'(i * 4)) nw++;
      next_cycle();
      m1_addr = m1_addr + 32'd4; m1_din = $urandom;
    end
    chk("lock_m1_stores", 32'(nw), 32'd8);
    chk("lock_m0_gnts", 32'(n0), 32'd0);
    m1_lock = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("unlock_m0_gnt", 32'(m0_gnt), 32'd1);

    // 5: alternating loads, one access per cycle, data routed per owner
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      vals[i] = $urandom;
      if (i % 2 == 0) begin
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m1_req = 1'b0;
      end else begin
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m0_req = 1'b0;
      end
      mem_dout = vals[i];
      @(negedge clk);
      chk("alt_gnt", 32'(m0_gnt | m1_gnt), 32'd1);
      if (i > 0) begin
        if (i % 2 == 1) chk("alt_m0_dout", m0_dout, vals[i]);
        else            chk("alt_m1_dout", m1_dout, vals[i]);
        chk("alt_rv", 32'(m0_rvalid ^ m1_rvalid), 32'd1);
      end
    end

    // 6: reset right after a granted load swallows the return
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80; m1_req = 1'b0;
    @(negedge clk);
    chk("rstld_gnt", 32'(m0_gnt), 32'd1);
    next_cycle();
    m0_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstld_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rstld_m1_rvalid", 32'(m1_rvalid), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rstld_after_m0_rvalid", 32'(m0_rvalid), 32'd0);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      next_cycle();
      rst = ($urandom_range(0, 199) == 0);
      mem_dout = $urandom;
      if ($urandom_range(0, 19) == 0) m1_lock = ~m1_lock;
      if (!m0_req || g0) begin
        m0_req = ($urandom_range(0, 3) != 0);
        m0_we = $urandom_range(0, 1); m0_addr = $urandom; m0_din = $urandom;
        m0_size = 2'($urandom_range(0, 2)); m0_sign = $urandom_range(0, 1);
      end else if ($urandom_range(0, 31) == 0) m0_req = 1'b0;
      if (!m1_req || g1) begin
        m1_req = ($urandom_range(0, 2) != 0);
        m1_we = $urandom_range(0, 1); m1_addr = $urandom; m1_din = $urandom;
        m1_size = 2'($urandom_range(0, 2)); m1_sign = $urandom_range(0, 1);
      end else if ($urandom_range(0, 63) == 0) m1_req = 1'b0;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
